// File: rtl/mux_scan_collector.sv
// Scan sequencer around an 8:1 mux: steps the select, collects one bit
// per slot and hands the assembled byte to a valid/ready consumer.
module mux_scan_collector #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic       start_i,
  input  logic       continuous_i,
  input  logic       mux_in_i,
  output logic [2:0] sel_o,
  output logic       busy_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       changed_o,
  output logic       overrun_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  localparam logic [3:0] LP_LAST =
    4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam state_t LP_NEXT =
    (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [6:0] r_shadow;
  logic [7:0] r_last_acc;
  logic       r_first;

  logic       w_done;
  logic       w_acc;
  logic       w_load;
  logic       w_first;
  logic [7:0] w_byte;
  logic [7:0] w_ref;

  // Bits 0..6 are shifted in from the top, so bit 0 lands at index 0.
  assign w_byte  = {mux_in_i, r_shadow};
  assign w_done  = (r_state == SAMPLE) && (sel_o == 3'd7);
  assign w_acc   = valid_o & ready_i;
  assign w_load  = w_done & (~valid_o | ready_i);
  // A byte accepted this cycle is the reference for the one replacing it.
  assign w_ref   = w_acc ? data_o : r_last_acc;
  assign w_first = w_acc ? 1'b0 : r_first;

  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_last_acc <= '0;
      r_first    <= 1'b1;
      sel_o      <= '0;
      busy_o     <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      changed_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          sel_o <= '0;
          if (start_i | continuous_i) begin
            r_state <= LP_NEXT;
            busy_o  <= 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == LP_LAST) begin
            r_cnt   <= '0;
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (sel_o != 3'd7) begin
            r_shadow <= {mux_in_i, r_shadow[6:1]};
            sel_o    <= sel_o + 3'd1;
            r_state  <= LP_NEXT;
          end else begin
            sel_o <= '0;
            if (continuous_i) begin
              r_state <= LP_NEXT;
            end else begin
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_acc) begin
        r_last_acc <= data_o;
        r_first    <= 1'b0;
        valid_o    <= 1'b0;
      end

      if (w_load) begin
        data_o    <= w_byte;
        valid_o   <= 1'b1;
        changed_o <= (w_byte != w_ref) | w_first;
      end else if (w_done) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_collector.sv
// Randomized bench for mux_scan_collector: two instances (settle 1 and 0)
// share stimulus and are compared every cycle against a slot-timing model.
module tb_mux_scan_collector;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic       ready;
  logic [7:0] pat;

  logic [2:0] sel   [2];
  logic       busy  [2];
  logic [7:0] data  [2];
  logic       valid [2];
  logic       chg   [2];
  logic       ovr   [2];
  logic       mux   [2];

  int n_vec = 0;
  int n_err = 0;
  int e     = 0;

  int         SV [2] = '{1, 0};
  bit         m_busy  [2];
  int         m_t0    [2];
  logic [2:0] m_sel   [2];
  logic [7:0] m_bits  [2];
  logic [7:0] m_data  [2];
  logic [7:0] m_last  [2];
  bit         m_valid [2];
  bit         m_chg   [2];
  bit         m_ovr   [2];
  bit         m_first [2];

  always #5 sysclk = ~sysclk;

  assign mux[0] = pat[sel[0]];
  assign mux[1] = pat[sel[1]];

  mux_scan_collector #(.SETTLE_CYCLES(1)) u_s1 (
    .sysclk      (sysclk),
    .sys_rst_n   (rst_n),
    .start_i     (start),
    .continuous_i(cont),
    .mux_in_i    (mux[0]),
    .sel_o       (sel[0]),
    .busy_o      (busy[0]),
    .data_o      (data[0]),
    .valid_o     (valid[0]),
    .ready_i     (ready),
    .changed_o   (chg[0]),
    .overrun_o   (ovr[0])
  );

  mux_scan_collector #(.SETTLE_CYCLES(0)) u_s0 (
    .sysclk      (sysclk),
    .sys_rst_n   (rst_n),
    .start_i     (start),
    .continuous_i(cont),
    .mux_in_i    (mux[1]),
    .sel_o       (sel[1]),
    .busy_o      (busy[1]),
    .data_o      (data[1]),
    .valid_o     (valid[1]),
    .ready_i     (ready),
    .changed_o   (chg[1]),
    .overrun_o   (ovr[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // Slot k of a scan started at edge t0 is sampled at t0+(k+1)*(S+1).
  task automatic model_step(input int d);
    int   off;
    int   k;
    bit   done;
    bit   was_valid;
    m_ovr[d] = 1'b0;
    if (!rst_n) begin
      m_busy[d]  = 1'b0;
      m_sel[d]   = '0;
      m_bits[d]  = '0;
      m_data[d]  = '0;
      m_last[d]  = '0;
      m_valid[d] = 1'b0;
      m_chg[d]   = 1'b0;
      m_first[d] = 1'b1;
      return;
    end
    done = 1'b0;
    if (!m_busy[d]) begin
      if (start || cont) begin
        m_busy[d] = 1'b1;
        m_t0[d]   = e;
        m_sel[d]  = '0;
      end
    end else begin
      off = e - m_t0[d];
      if (off % (SV[d] + 1) == 0) begin
        k = off / (SV[d] + 1) - 1;
        m_bits[d][k] = pat[k];
        if (k == 7) begin
          done     = 1'b1;
          m_sel[d] = '0;
          if (cont) m_t0[d] = e;
          else m_busy[d] = 1'b0;
        end else begin
          m_sel[d] = 3'(k + 1);
        end
      end
    end
    was_valid = m_valid[d];
    if (m_valid[d] && ready) begin
      m_last[d]  = m_data[d];
      m_first[d] = 1'b0;
      m_valid[d] = 1'b0;
    end
    if (done) begin
      if (was_valid && !ready) begin
        m_ovr[d] = 1'b1;
      end else begin
        m_data[d]  = m_bits[d];
        m_chg[d]   = (m_bits[d] != m_last[d]) || m_first[d];
        m_valid[d] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge sysclk);
    model_step(0);
    model_step(1);
    e++;
    @(negedge sysclk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s%0d.sel", SV[d]), 8'(sel[d]), 8'(m_sel[d]));
      chk($sformatf("s%0d.busy", SV[d]), 8'(busy[d]), 8'(m_busy[d]));
      chk($sformatf("s%0d.valid", SV[d]), 8'(valid[d]), 8'(m_valid[d]));
      chk($sformatf("s%0d.data", SV[d]), data[d], m_data[d]);
      chk($sformatf("s%0d.changed", SV[d]), 8'(chg[d]), 8'(m_chg[d]));
      chk($sformatf("s%0d.overrun", SV[d]), 8'(ovr[d]), 8'(m_ovr[d]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    ready = 1'b1;
    pat   = 8'h00;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    pat = 8'hA5;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (20) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (20) cycle();
    pat = 8'h3C;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (20) cycle();

    ready = 1'b0;
    pat   = 8'h11;
    cont  = 1'b1;
    repeat (18) cycle();
    pat = 8'h22;
    repeat (20) cycle();
    ready = 1'b1;
    repeat (20) cycle();
    cont = 1'b0;
    repeat (20) cycle();

    pat   = 8'h5A;
    start = 1'b1;
    repeat (10) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) cycle();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) cont = ~cont;
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) pat = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
